set_job_dispatcher: RTL and testbench
=====================================

Name: set_job_dispatcher

Overview:
- Sits directly upstream of the SET candidate-counting engine. Feeds it one job (central, radius, mode) at a time and collects its candidate count.
- Buffers host commands in a small FIFO and launches each job with a single-cycle en pulse.
- Holds central, radius and mode stable for the whole job, because the engine reads them continuously while computing.
- Captures candidate on the engine's valid pulse and presents it, with a job tag, on a valid/ready result port. A watchdog flags jobs that never complete.

Parameters:
- DEPTH, 4, command FIFO entries; power of 2, at least 2.
- TAG_W, 4, width of the job tag. The tag is a wrapping sequence number assigned at command accept.
- TIMEOUT, 1023, maximum cycles in WAIT before the job is aborted. Must be less than 2^16.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  host command ready; equals !fifo_full, combinational from the FIFO count.
- cmd_central  in  24  packed centres, engine format {xA,yA,xB,yB,xC,yC}, 4 bits each.
- cmd_radius  in  12  packed radii {rA,rB,rC}, 4 bits each.
- cmd_mode  in  2  0=A, 1=A&B, 2=A^B, 3=exactly two of A,B,C.
- fifo_level  out  clog2(DEPTH)+1  entries currently queued.
- set_en  out  1  one-cycle job launch pulse to the engine.
- set_central  out  24  registered; stable from launch until capture or abort.
- set_radius  out  12  registered; same stability rule as set_central.
- set_mode  out  2  registered; same stability rule as set_central.
- set_valid  in  1  engine done pulse.
- set_candidate  in  8  engine count; sampled only when set_valid=1.
- res_valid  out  1  result available.
- res_ready  in  1  result consumer ready.
- res_candidate  out  8  captured count.
- res_tag  out  TAG_W  tag of the job that produced this result.
- res_err  out  1  1 = job aborted by timeout; res_candidate=0 in that case.

Behaviour:
- Reset (rst=1 at a clk edge):
  - FIFO empty, tag counter 0, state IDLE, watchdog 0.
  - set_en=0; set_central, set_radius, set_mode = 0.
  - res_valid=0, res_candidate=0, res_tag=0, res_err=0.
  - cmd_ready=1 from the first cycle after reset.
- Reset mid-job: drops the queue and any in-flight job, with no result emitted.
- Command accept: on cmd_valid & cmd_ready, push {central, radius, mode, tag}, then tag <= tag+1 (wraps mod 2^TAG_W).
- Full FIFO: cmd_ready=0 and no write. There is no same-cycle push/pop bypass at full.
- Empty FIFO: a pushed entry is visible to the FSM the cycle after the push.
- Slot free condition: slot_free = !res_valid | res_ready.
- Result handshake:
  - res_valid clears on res_valid & res_ready unless a new capture happens the same cycle.
  - res_* stay stable while res_valid=1 and res_ready=0.
- FSM state IDLE:
  - Condition to launch: FIFO non-empty and slot_free.
  - On launch: pop the head, load set_central/set_radius/set_mode and an internal job tag, clear the watchdog, go to LAUNCH.
  - Otherwise remain in IDLE.
- FSM state LAUNCH:
  - set_en=1 for exactly this one cycle.
  - Go to WAIT.
- FSM state WAIT:
  - Watchdog increments each cycle.
  - On set_valid=1: res_candidate <= set_candidate, res_tag <= job tag, res_err <= 0, res_valid <= 1; go to IDLE.
  - Else if watchdog == TIMEOUT: res_candidate <= 0, res_err <= 1, res_valid <= 1; go to IDLE.
  - If set_valid and timeout occur in the same cycle, set_valid wins.
- Result slot at capture: the slot is guaranteed empty, because launch required slot_free.
- Engine inputs:
  - set_valid outside WAIT is ignored.
  - set_busy is not used; sequencing relies only on set_valid.
- Latency:
  - Command pushed into an empty FIFO with the slot free: set_en asserts 2 cycles after the accept edge.
  - set_valid at cycle N: res_valid=1 at cycle N+1.
  - Earliest next set_en is N+2, which requires FIFO non-empty and slot_free at N+1.
- set_* outputs hold their last job's value between jobs.
- Ordering: results are emitted strictly in command order, with consecutive tags.

Test Plan:
- Single job: reset, push central=24'h44_0000, radius=12'h300, mode=0. Bench engine model answers set_valid with set_candidate=8'd29 100 cycles after set_en. Expect: set_en once, 2 cycles after accept; set_* stable throughout; res_valid with candidate=29, tag=0, err=0.
- Back-pressure and full: hold res_ready=0 and push 6 commands with DEPTH=4.
  - Expect 5 accepted: 1 launched and 4 queued; cmd_ready=0 afterwards; fifo_level=4.
  - Expect no second set_en until res_ready=1.
  - Expect tags 0..4 emitted in order once released.
- Timeout: TIMEOUT=20, engine never pulses valid. Expect res_valid 21 cycles after set_en, with err=1, candidate=0. The next queued job then launches normally.
- Valid/timeout tie: set_valid on the exact TIMEOUT cycle with candidate=8'd7. Expect err=0, candidate=7.
- Tag wrap: TAG_W=2, 6 jobs. Expect tags 0,1,2,3,0,1.
- Reset mid-WAIT with 2 entries queued: assert rst 1 cycle. Expect no res_valid, fifo_level=0, cmd_ready=1; the next job gets tag 0.

Source files
------------

// File: rtl/set_job_dispatcher_if.sv
// Signal bundle for set_job_dispatcher: host command port, SET engine port and result port.
// fsm_state mirrors the dispatcher FSM (0=IDLE, 1=LAUNCH, 2=WAIT) for observation.
interface set_job_dispatcher_if #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  // valid/ready: a transfer happens on a rising clk edge where valid and ready are both 1;
  // the source keeps its payload stable while valid=1 and ready=0.
  logic             cmd_valid;
  logic             cmd_ready;
  logic [23:0]      cmd_central;
  logic [11:0]      cmd_radius;
  logic [1:0]       cmd_mode;
  logic [LVL_W-1:0] fifo_level;
  logic             set_en;
  logic [23:0]      set_central;
  logic [11:0]      set_radius;
  logic [1:0]       set_mode;
  logic             set_valid;
  logic [7:0]       set_candidate;
  logic             res_valid;
  logic             res_ready;
  logic [7:0]       res_candidate;
  logic [TAG_W-1:0] res_tag;
  logic             res_err;
  logic [1:0]       fsm_state;

  modport slave (
    input  cmd_valid, cmd_central, cmd_radius, cmd_mode, set_valid, set_candidate, res_ready,
    output cmd_ready, fifo_level, set_en, set_central, set_radius, set_mode,
           res_valid, res_candidate, res_tag, res_err, fsm_state
  );

  modport master (
    output cmd_valid, cmd_central, cmd_radius, cmd_mode, set_valid, set_candidate, res_ready,
    input  cmd_ready, fifo_level, set_en, set_central, set_radius, set_mode,
           res_valid, res_candidate, res_tag, res_err, fsm_state
  );
endinterface

// File: rtl/set_job_dispatcher.sv
// Queues host jobs, launches them one at a time into the SET candidate engine and
// returns each tagged count (or a timeout error) on a valid/ready result port.
module set_job_dispatcher #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 1023
) (
  input logic               clk,
  input logic               rst,
  set_job_dispatcher_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = 24 + 12 + 2 + TAG_W;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  state_t           state;
  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] count;
  logic [TAG_W-1:0] tag;
  logic [TAG_W-1:0] job_tag;
  logic [15:0]      wd;

  logic             set_en_q;
  logic [23:0]      central_q;
  logic [11:0]      radius_q;
  logic [1:0]       mode_q;
  logic             res_valid_q;
  logic [7:0]       res_cand_q;
  logic [TAG_W-1:0] res_tag_q;
  logic             res_err_q;

  logic full;
  logic empty;
  logic push;
  logic slot_free;
  logic launch;

  assign full      = (count == LVL_W'(DEPTH));
  assign empty     = (count == '0);
  assign push      = bus.cmd_valid & ~full;
  assign slot_free = ~res_valid_q | bus.res_ready;
  assign launch    = (state == S_IDLE) & ~empty & slot_free;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.cmd_central, bus.cmd_radius, bus.cmd_mode, tag};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      tag         <= '0;
      job_tag     <= '0;
      wd          <= '0;
      set_en_q    <= 1'b0;
      central_q   <= '0;
      radius_q    <= '0;
      mode_q      <= '0;
      res_valid_q <= 1'b0;
      res_cand_q  <= '0;
      res_tag_q   <= '0;
      res_err_q   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        tag    <= tag + TAG_W'(1);
      end
      if (launch) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + LVL_W'(push) - LVL_W'(launch);

      // A capture below overrides this clear when both land on the same edge.
      if (res_valid_q && bus.res_ready) res_valid_q <= 1'b0;

      case (state)
        S_IDLE: begin
          if (launch) begin
            {central_q, radius_q, mode_q, job_tag} <= mem[rd_ptr];
            wd       <= '0;
            set_en_q <= 1'b1;
            state    <= S_LAUNCH;
          end
        end
        // The watchdog already counts here, so it equals the number of WAIT cycles
        // elapsed and hits TIMEOUT on the TIMEOUT-th cycle spent in WAIT.
        S_LAUNCH: begin
          set_en_q <= 1'b0;
          wd       <= wd + 16'd1;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          wd <= wd + 16'd1;
          if (bus.set_valid) begin
            res_cand_q  <= bus.set_candidate;
            res_tag_q   <= job_tag;
            res_err_q   <= 1'b0;
            res_valid_q <= 1'b1;
            state       <= S_IDLE;
          end else if (wd == 16'(TIMEOUT)) begin
            res_cand_q  <= '0;
            res_tag_q   <= job_tag;
            res_err_q   <= 1'b1;
            res_valid_q <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready     = ~full;
  assign bus.fifo_level    = count;
  assign bus.set_en        = set_en_q;
  assign bus.set_central   = central_q;
  assign bus.set_radius    = radius_q;
  assign bus.set_mode      = mode_q;
  assign bus.res_valid     = res_valid_q;
  assign bus.res_candidate = res_cand_q;
  assign bus.res_tag       = res_tag_q;
  assign bus.res_err       = res_err_q;
  assign bus.fsm_state     = state;
endmodule

// File: tb/tb_set_job_dispatcher.sv
// Directed bench for set_job_dispatcher: one instance with default tag/timeout and one with
// TAG_W=2, TIMEOUT=20; a bench engine model answers launches and feeds a result scoreboard.
module tb_set_job_dispatcher;
  localparam int W = 13;

  typedef struct {
    logic [37:0] cmd;
    logic [3:0]  tag;
    int          delay;
    logic [7:0]  cand;
  } job_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        sel;
  logic        cmd_valid;
  logic [23:0] cmd_central;
  logic [11:0] cmd_radius;
  logic [1:0]  cmd_mode;
  logic        eng_valid;
  logic [7:0]  eng_cand;
  logic        res_ready;

  set_job_dispatcher_if #(.DEPTH(4), .TAG_W(4)) if_a ();
  set_job_dispatcher_if #(.DEPTH(4), .TAG_W(2)) if_b ();

  set_job_dispatcher #(.DEPTH(4), .TAG_W(4), .TIMEOUT(1023)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  set_job_dispatcher #(.DEPTH(4), .TAG_W(2), .TIMEOUT(20))   dut_b (.clk(clk), .rst(rst), .bus(if_b));

  assign if_a.cmd_valid     = cmd_valid & ~sel;
  assign if_b.cmd_valid     = cmd_valid & sel;
  assign if_a.cmd_central   = cmd_central;
  assign if_b.cmd_central   = cmd_central;
  assign if_a.cmd_radius    = cmd_radius;
  assign if_b.cmd_radius    = cmd_radius;
  assign if_a.cmd_mode      = cmd_mode;
  assign if_b.cmd_mode      = cmd_mode;
  assign if_a.set_valid     = eng_valid & ~sel;
  assign if_b.set_valid     = eng_valid & sel;
  assign if_a.set_candidate = eng_cand;
  assign if_b.set_candidate = eng_cand;
  assign if_a.res_ready     = sel ? 1'b1 : res_ready;
  assign if_b.res_ready     = sel ? res_ready : 1'b1;

  logic        cmd_ready_m, set_en_m, res_valid_m, res_err_m;
  logic [2:0]  fifo_level_m;
  logic [23:0] set_central_m;
  logic [11:0] set_radius_m;
  logic [1:0]  set_mode_m, state_m;
  logic [7:0]  res_cand_m;
  logic [3:0]  res_tag_m;

  assign cmd_ready_m   = sel ? if_b.cmd_ready     : if_a.cmd_ready;
  assign set_en_m      = sel ? if_b.set_en        : if_a.set_en;
  assign res_valid_m   = sel ? if_b.res_valid     : if_a.res_valid;
  assign res_err_m     = sel ? if_b.res_err       : if_a.res_err;
  assign fifo_level_m  = sel ? if_b.fifo_level    : if_a.fifo_level;
  assign set_central_m = sel ? if_b.set_central   : if_a.set_central;
  assign set_radius_m  = sel ? if_b.set_radius    : if_a.set_radius;
  assign set_mode_m    = sel ? if_b.set_mode      : if_a.set_mode;
  assign state_m       = sel ? if_b.fsm_state     : if_a.fsm_state;
  assign res_cand_m    = sel ? if_b.res_candidate : if_a.res_candidate;
  assign res_tag_m     = sel ? {2'b00, if_b.res_tag} : if_a.res_tag;

  int n_cmp = 0;
  int n_err = 0;
  int n_res = 0;
  int n_launch = 0;
  int tag_model = 0;

  logic [W-1:0] exp_q[$];
  job_t         job_q[$];

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic send(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m,
                      input int d, input logic [7:0] k, output bit acc);
    job_t j;
    @(negedge clk);
    cmd_valid   = 1'b1;
    cmd_central = c;
    cmd_radius  = r;
    cmd_mode    = m;
    #1;
    acc = cmd_ready_m;
    if (acc) begin
      j.cmd   = {c, r, m};
      j.tag   = 4'(tag_model % (sel ? 4 : 16));
      j.delay = d;
      j.cand  = k;
      job_q.push_back(j);
      tag_model++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    job_q.delete();
    tag_model = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_cmd_ready", cmd_ready_m, 1);
    check("rst_fifo_level", fifo_level_m, 0);
    check("rst_res_valid", res_valid_m, 0);
    check("rst_state", state_m, 0);
  endtask

  task automatic wait_res(input int target, input int budget);
    for (int i = 0; i < budget && n_res < target; i++) @(negedge clk);
    #2;
    check("results_done", n_res, target);
  endtask

  // Bench engine: answers each launch after the job's delay, or never (delay < 0).
  job_t cur;
  bit   aborted;
  int   limit;
  initial begin
    eng_valid = 1'b0;
    eng_cand  = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && set_en_m) begin
        n_launch++;
        if (job_q.size() == 0) begin
          check("launch_without_cmd", 1, 0);
        end else begin
          cur = job_q.pop_front();
          check("launch_payload", {set_central_m, set_radius_m, set_mode_m}, cur.cmd);
          aborted = 1'b0;
          limit   = (cur.delay < 0) ? (sel ? 20 : 1023) : cur.delay;
          for (int i = 1; i <= limit && !aborted; i++) begin
            @(negedge clk);
            #1;
            if (rst) aborted = 1'b1;
            else begin
              check("hold_payload", {set_central_m, set_radius_m, set_mode_m}, cur.cmd);
              check("wait_en_res", {set_en_m, res_valid_m}, 2'b00);
            end
          end
          if (!aborted) begin
            if (cur.delay >= 0) begin
              eng_valid = 1'b1;
              eng_cand  = cur.cand;
              exp_q.push_back({1'b0, cur.tag, cur.cand});
            end else begin
              exp_q.push_back({1'b1, cur.tag, 8'h00});
            end
            @(negedge clk);
            #1;
            eng_valid = 1'b0;
            if (!rst) check("result_latency", res_valid_m, 1);
          end
        end
      end
    end
  end

  // Result monitor: scoreboard pop on handshake, stability check under back-pressure.
  logic [W-1:0] mon_cur, mon_held;
  bit           have_held = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      #1;
      mon_cur = {res_err_m, res_tag_m, res_cand_m};
      if (rst || !res_valid_m) have_held = 1'b0;
      else begin
        if (have_held) check("res_stable", mon_cur, mon_held);
        if (res_ready) begin
          have_held = 1'b0;
          if (exp_q.size() == 0) check("res_unexpected", mon_cur, 0);
          else check("result", mon_cur, exp_q.pop_front());
          n_res++;
        end else begin
          mon_held  = mon_cur;
          have_held = 1'b1;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "bench timeout");
  end

  bit acc;
  int n_acc, base_res, base_launch;
  initial begin
    sel = 1'b0; rst = 1'b1; cmd_valid = 1'b0; cmd_central = '0; cmd_radius = '0;
    cmd_mode = '0; res_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_cmd_ready", cmd_ready_m, 1);
    check("reset_fifo_level", fifo_level_m, 0);
    check("reset_set_en", set_en_m, 0);
    check("reset_set_payload", {set_central_m, set_radius_m, set_mode_m}, 0);
    check("reset_res_valid", res_valid_m, 0);
    check("reset_res_fields", {res_err_m, res_tag_m, res_cand_m}, 0);

    // Single job: launch latency, hold, result 29 / tag 0.
    send(24'h44_0000, 12'h300, 2'd0, 100, 8'd29, acc);
    check("single_accept", acc, 1);
    #1;
    check("launch_not_early", set_en_m, 0);
    check("level_before_launch", fifo_level_m, 1);
    @(negedge clk);
    #1;
    check("launch_latency", set_en_m, 1);
    wait_res(1, 150);
    check("single_launches", n_launch, 1);

    // Back-pressure: result slot blocked, FIFO fills, tags 0..4 released in order.
    do_reset();
    res_ready   = 1'b0;
    n_acc       = 0;
    base_res    = n_res;
    base_launch = n_launch;
    for (int i = 0; i < 6; i++) begin
      send(24'h12_3456 + 24'(i), 12'h0a5 + 12'(i), 2'(i), 5, 8'h40 + 8'(i), acc);
      if (acc) n_acc++;
    end
    repeat (20) @(negedge clk);
    #1;
    check("bp_accepted", n_acc, 5);
    check("bp_cmd_ready", cmd_ready_m, 0);
    check("bp_fifo_level", fifo_level_m, 4);
    check("bp_single_launch", n_launch - base_launch, 1);
    check("bp_res_valid", res_valid_m, 1);
    res_ready = 1'b1;
    wait_res(base_res + 5, 200);
    check("bp_drained_level", fifo_level_m, 0);
    check("bp_drained_ready", cmd_ready_m, 1);

    // Reset mid-WAIT with two entries queued.
    base_res = n_res;
    for (int i = 0; i < 3; i++) send(24'hab_cdef, 12'h111 * 12'(i + 1), 2'd3, 300, 8'd99, acc);
    repeat (5) @(negedge clk);
    #1;
    check("mid_wait_state", state_m, 2);
    check("mid_wait_level", fifo_level_m, 2);
    do_reset();
    repeat (40) @(negedge clk);
    #1;
    check("post_reset_no_result", n_res, base_res);
    check("post_reset_res_valid", res_valid_m, 0);
    send(24'h00_0f0f, 12'h222, 2'd1, 3, 8'd55, acc);
    wait_res(base_res + 1, 60);

    // Timeout then a normal job, on the TIMEOUT=20 / TAG_W=2 instance.
    @(negedge clk);
    sel = 1'b1;
    do_reset();
    base_res = n_res;
    send(24'h31_4159, 12'h765, 2'd2, -1, 8'd0, acc);
    send(24'h27_1828, 12'h123, 2'd1, 4, 8'h3c, acc);
    wait_res(base_res + 2, 120);

    // set_valid on the exact timeout cycle wins.
    send(24'h55_aa55, 12'h456, 2'd3, 20, 8'd7, acc);
    wait_res(base_res + 3, 80);

    // Tag wrap with TAG_W=2.
    do_reset();
    base_res = n_res;
    for (int i = 0; i < 6; i++) send(24'h10_0000 + 24'(i), 12'h321, 2'(i), 2, 8'h80 + 8'(i), acc);
    wait_res(base_res + 6, 200);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    check("jobs_consumed", job_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
